dmem_sync: RTL and testbench

Synchronous, parametrised single-port data memory for the RISC-V datapath. It replaces the asynchronous, tri-state byte memory. Features:
- Word width and depth are configurable.
- Writes are byte-lane masked.
- Requests and responses use a valid/ready handshake.
- A programmable wait-state count emulates slower memory.
- An optional clear-on-reset sequencer zeroes the array after reset.

It sits between the core's load/store unit and the data array; the core must not issue a request until `req_ready` is high.

---
 rtl/dmem_sync.sv | 138 +++++++++++++
 tb/tb_dmem_sync.sv | 409 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dmem_sync.sv
// Synchronous single-port data memory with byte-lane write masking, valid/ready handshakes,
// a programmable wait-state count and an optional post-reset clear sequence.
module dmem_sync #(
    parameter int unsigned DATA_W         = 32,
    parameter int unsigned ADDR_W         = 5,
    parameter int unsigned LATENCY        = 1,
    parameter bit          CLEAR_ON_RESET = 1'b1
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                req_valid,
    output logic                req_ready,
    input  logic                req_we,
    input  logic [ADDR_W-1:0]   req_addr,
    input  logic [DATA_W-1:0]   req_wdata,
    input  logic [DATA_W/8-1:0] req_be,
    output logic                rsp_valid,
    input  logic                rsp_ready,
    output logic [DATA_W-1:0]   rsp_rdata,
    output logic                init_done
);

    localparam int unsigned NB    = DATA_W / 8;
    localparam int unsigned DEPTH = 1 << ADDR_W;
    localparam logic [3:0]  LAT   = 4'(LATENCY);

    typedef enum logic [1:0] {
        StInit,
        StIdle,
        StWait,
        StResp
    } state_e;

    state_e              state;
    logic [ADDR_W-1:0]   clr;
    logic [3:0]          cnt;

    logic                we_q;
    logic [ADDR_W-1:0]   addr_q;
    logic [DATA_W-1:0]   wdata_q;
    logic [NB-1:0]       be_q;

    logic [DATA_W-1:0]   mem [DEPTH];

    logic [DATA_W-1:0]   cur;
    logic [DATA_W-1:0]   merged;
    logic                access;
    logic                mem_we;
    logic [ADDR_W-1:0]   mem_waddr;
    logic [DATA_W-1:0]   mem_wdata;

    assign req_ready = (state == StIdle);
    assign access    = (state == StWait) && (cnt == 4'd0);
    assign cur       = mem[addr_q];

    always_comb begin
        merged = cur;
        for (int i = 0; i < NB; i++) begin
            if (be_q[i]) begin
                merged[8*i +: 8] = wdata_q[8*i +: 8];
            end
        end
    end

    // Reset has priority: a write whose access edge coincides with reset is dropped.
    always_comb begin
        mem_we    = 1'b0;
        mem_waddr = addr_q;
        mem_wdata = merged;
        if (rst_n) begin
            if (state == StInit && CLEAR_ON_RESET) begin
                mem_we    = 1'b1;
                mem_waddr = clr;
                mem_wdata = '0;
            end else if (access && we_q) begin
                mem_we = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem[mem_waddr] <= mem_wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= StInit;
            clr       <= '0;
            cnt       <= '0;
            rsp_valid <= 1'b0;
            rsp_rdata <= '0;
            init_done <= 1'b0;
            we_q      <= 1'b0;
            addr_q    <= '0;
            wdata_q   <= '0;
            be_q      <= '0;
        end else begin
            case (state)
                StInit: begin
                    clr <= clr + 1'b1;
                    if (!CLEAR_ON_RESET || (&clr)) begin
                        state     <= StIdle;
                        init_done <= 1'b1;
                    end
                end
                StIdle: begin
                    if (req_valid) begin
                        we_q    <= req_we;
                        addr_q  <= req_addr;
                        wdata_q <= req_wdata;
                        be_q    <= req_be;
                        cnt     <= LAT;
                        state   <= StWait;
                    end
                end
                StWait: begin
                    if (cnt != 4'd0) begin
                        cnt <= cnt - 4'd1;
                    end else begin
                        rsp_rdata <= we_q ? merged : cur;
                        rsp_valid <= 1'b1;
                        state     <= StResp;
                    end
                end
                StResp: begin
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                        state     <= StIdle;
                    end
                end
                default: state <= StInit;
            endcase
        end
    end

endmodule

// File: tb/tb_dmem_sync.sv
// Self-checking bench for dmem_sync: instance 0 has LATENCY=3 with clear-on-reset,
// instance 1 has LATENCY=0 with contents retained across reset.
module tb_dmem_sync;

    logic                  clk;
    logic [1:0]            rst_n;
    logic [1:0]            req_valid;
    wire  [1:0]            req_ready;
    logic [1:0]            req_we;
    logic [1:0][4:0]       req_addr;
    logic [1:0][31:0]      req_wdata;
    logic [1:0][3:0]       req_be;
    wire  [1:0]            rsp_valid;
    logic [1:0]            rsp_ready;
    wire  [1:0][31:0]      rsp_rdata;
    wire  [1:0]            init_done;

    int n_cmp;
    int n_bad;

    logic [31:0] model [2][32];
    bit          known [2][32];

    dmem_sync #(.DATA_W(32), .ADDR_W(5), .LATENCY(3), .CLEAR_ON_RESET(1'b1)) u_a (
        .clk(clk), .rst_n(rst_n[0]), .req_valid(req_valid[0]), .req_ready(req_ready[0]),
        .req_we(req_we[0]), .req_addr(req_addr[0]), .req_wdata(req_wdata[0]),
        .req_be(req_be[0]), .rsp_valid(rsp_valid[0]), .rsp_ready(rsp_ready[0]),
        .rsp_rdata(rsp_rdata[0]), .init_done(init_done[0])
    );

    dmem_sync #(.DATA_W(32), .ADDR_W(5), .LATENCY(0), .CLEAR_ON_RESET(1'b0)) u_b (
        .clk(clk), .rst_n(rst_n[1]), .req_valid(req_valid[1]), .req_ready(req_ready[1]),
        .req_we(req_we[1]), .req_addr(req_addr[1]), .req_wdata(req_wdata[1]),
        .req_be(req_be[1]), .rsp_valid(rsp_valid[1]), .rsp_ready(rsp_ready[1]),
        .rsp_rdata(rsp_rdata[1]), .init_done(init_done[1])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #3000000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1);
    end

    function automatic int lat_exp(input int d);
        return (d == 0) ? 4 : 1;
    endfunction

    function automatic int init_edges(input int d);
        return (d == 0) ? 32 : 1;
    endfunction

    function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] wd,
                                          input logic [3:0] be);
        logic [31:0] mask;
        mask = {{8{be[3]}}, {8{be[2]}}, {8{be[1]}}, {8{be[0]}}};
        return (old & ~mask) | (wd & mask);
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_ready(input int d, output int edges);
        edges = 0;
        do begin
            step();
            edges++;
        end while (!req_ready[d] && edges < 200);
    endtask

    task automatic do_txn(input int d, input logic we, input logic [4:0] addr,
                          input logic [31:0] wdata, input logic [3:0] be, input int hold,
                          output logic [31:0] rdata, output int lat);
        int n;
        n = 0;
        while (!req_ready[d] && n < 100) begin
            step();
            n++;
        end
        if (!req_ready[d]) begin
            n_cmp++;
            n_bad++;
            $display("FAIL ready_timeout[%0d]: req_ready=%b required 1", d, req_ready[d]);
        end
        req_valid[d] = 1'b1;
        req_we[d]    = we;
        req_addr[d]  = addr;
        req_wdata[d] = wdata;
        req_be[d]    = be;
        step();
        req_valid[d] = 1'b0;
        lat = 0;
        while (!rsp_valid[d] && lat < 40) begin
            rsp_ready[d] = 1'($urandom_range(0, 1));
            step();
            lat++;
        end
        rsp_ready[d] = 1'b0;
        rdata = rsp_rdata[d];
        repeat (hold) step();
        rsp_ready[d] = 1'b1;
        step();
        rsp_ready[d] = 1'b0;
    endtask

    task automatic test_reset();
        int ea, eb;
        rst_n = 2'b00;
        repeat (3) step();
        for (int d = 0; d < 2; d++) begin
            n_cmp++;
            if (req_ready[d] !== 1'b0 || rsp_valid[d] !== 1'b0 || rsp_rdata[d] !== 32'h0 ||
                init_done[d] !== 1'b0) begin
                n_bad++;
                $display("FAIL reset_outputs[%0d]: rdy=%b rv=%b rd=%h done=%b required 0 0 0 0",
                         d, req_ready[d], rsp_valid[d], rsp_rdata[d], init_done[d]);
            end
        end
        rst_n = 2'b11;
        ea = 0;
        eb = 0;
        for (int k = 1; k <= 100 && (ea == 0 || eb == 0); k++) begin
            step();
            if (req_ready[0] && ea == 0) ea = k;
            if (req_ready[1] && eb == 0) eb = k;
        end
        n_cmp++;
        if (ea != 32 || init_done[0] !== 1'b1) begin
            n_bad++;
            $display("FAIL init_edges[0]: edges=%0d done=%b required 32 1", ea, init_done[0]);
        end
        n_cmp++;
        if (eb != 1 || init_done[1] !== 1'b1) begin
            n_bad++;
            $display("FAIL init_edges[1]: edges=%0d done=%b required 1 1", eb, init_done[1]);
        end
        for (int a = 0; a < 32; a++) begin
            model[0][a] = 32'h0;
            known[0][a] = 1'b1;
            known[1][a] = 1'b0;
        end
    endtask

    task automatic test_clear();
        logic [31:0] r;
        int lat, edges;
        int addrs[3] = '{0, 17, 31};
        foreach (addrs[i]) do_txn(0, 1'b1, 5'(addrs[i]), $urandom | 32'h1, 4'hF, 0, r, lat);
        rst_n[0] = 1'b0;
        repeat (2) step();
        rst_n[0] = 1'b1;
        wait_ready(0, edges);
        n_cmp++;
        if (edges != 32) begin
            n_bad++;
            $display("FAIL clear_edges: edges=%0d required 32", edges);
        end
        foreach (addrs[i]) begin
            do_txn(0, 1'b0, 5'(addrs[i]), 32'h0, 4'h0, 0, r, lat);
            n_cmp++;
            if (r !== 32'h0) begin
                n_bad++;
                $display("FAIL clear_read[%0d]: got %h required 00000000", addrs[i], r);
            end
        end
        for (int a = 0; a < 32; a++) model[0][a] = 32'h0;
    endtask

    task automatic test_full_word();
        logic [31:0] r;
        int lat;
        for (int d = 0; d < 2; d++) begin
            do_txn(d, 1'b1, 5'd5, 32'hDEADBEEF, 4'hF, 0, r, lat);
            n_cmp++;
            if (r !== 32'hDEADBEEF || lat != lat_exp(d)) begin
                n_bad++;
                $display("FAIL full_write[%0d]: data=%h lat=%0d required deadbeef %0d",
                         d, r, lat, lat_exp(d));
            end
            do_txn(d, 1'b0, 5'd5, 32'h0, 4'h0, 1, r, lat);
            n_cmp++;
            if (r !== 32'hDEADBEEF || lat != lat_exp(d)) begin
                n_bad++;
                $display("FAIL full_read[%0d]: data=%h lat=%0d required deadbeef %0d",
                         d, r, lat, lat_exp(d));
            end
            model[d][5] = 32'hDEADBEEF;
            known[d][5] = 1'b1;
        end
    endtask

    task automatic test_byte_mask();
        logic [31:0] r;
        int lat;
        for (int d = 0; d < 2; d++) begin
            do_txn(d, 1'b1, 5'd9, 32'h11223344, 4'hF, 0, r, lat);
            do_txn(d, 1'b1, 5'd9, 32'hAABBCCDD, 4'b0101, 0, r, lat);
            n_cmp++;
            if (r !== 32'h11BB33DD) begin
                n_bad++;
                $display("FAIL mask_0101[%0d]: got %h required 11bb33dd", d, r);
            end
            do_txn(d, 1'b1, 5'd9, 32'hFFFFFFFF, 4'b0000, 0, r, lat);
            n_cmp++;
            if (r !== 32'h11BB33DD) begin
                n_bad++;
                $display("FAIL mask_none[%0d]: got %h required 11bb33dd", d, r);
            end
            do_txn(d, 1'b0, 5'd9, 32'h0, 4'h0, 0, r, lat);
            n_cmp++;
            if (r !== 32'h11BB33DD) begin
                n_bad++;
                $display("FAIL mask_read[%0d]: got %h required 11bb33dd", d, r);
            end
            model[d][9] = 32'h11BB33DD;
            known[d][9] = 1'b1;
        end
    endtask

    task automatic test_latency_backpressure();
        logic [31:0] r, wd;
        int lat, bad;
        wd = $urandom;
        do_txn(0, 1'b1, 5'd12, wd, 4'hF, 0, r, lat);
        model[0][12] = wd;
        rsp_ready[0] = 1'b0;
        req_valid[0] = 1'b1;
        req_we[0]    = 1'b0;
        req_addr[0]  = 5'd12;
        step();
        req_valid[0] = 1'b0;
        bad = 0;
        for (int c = 1; c <= 3; c++) begin
            step();
            if (req_ready[0] !== 1'b0 || rsp_valid[0] !== 1'b0) bad++;
        end
        n_cmp++;
        if (bad != 0) begin
            n_bad++;
            $display("FAIL latency_wait: %0d early cycles required 0", bad);
        end
        step();
        n_cmp++;
        if (rsp_valid[0] !== 1'b1 || rsp_rdata[0] !== wd) begin
            n_bad++;
            $display("FAIL latency_rise: rv=%b data=%h required 1 %h", rsp_valid[0],
                     rsp_rdata[0], wd);
        end
        bad = 0;
        for (int c = 0; c < 5; c++) begin
            if (c == 2) begin
                req_valid[0] = 1'b1;
                req_we[0]    = 1'b1;
                req_addr[0]  = 5'd20;
                req_wdata[0] = ~wd;
                req_be[0]    = 4'hF;
            end else begin
                req_valid[0] = 1'b0;
            end
            step();
            if (rsp_valid[0] !== 1'b1 || rsp_rdata[0] !== wd || req_ready[0] !== 1'b0) bad++;
        end
        req_valid[0] = 1'b0;
        n_cmp++;
        if (bad != 0) begin
            n_bad++;
            $display("FAIL backpressure_hold: %0d unstable cycles required 0", bad);
        end
        rsp_ready[0] = 1'b1;
        step();
        rsp_ready[0] = 1'b0;
        n_cmp++;
        if (rsp_valid[0] !== 1'b0 || req_ready[0] !== 1'b1) begin
            n_bad++;
            $display("FAIL backpressure_release: rv=%b rdy=%b required 0 1", rsp_valid[0],
                     req_ready[0]);
        end
        do_txn(0, 1'b0, 5'd20, 32'h0, 4'h0, 0, r, lat);
        n_cmp++;
        if (r !== model[0][20]) begin
            n_bad++;
            $display("FAIL backpressure_ignored: got %h required %h", r, model[0][20]);
        end
    endtask

    task automatic test_reset_mid_op();
        logic [31:0] r;
        int lat, edges, bad;
        // Instance 1: reset lands on the access edge, so the write must never happen.
        do_txn(1, 1'b1, 5'd2, 32'h0BADF00D, 4'hF, 0, r, lat);
        model[1][2] = 32'h0BADF00D;
        known[1][2] = 1'b1;
        req_valid[1] = 1'b1;
        req_we[1]    = 1'b1;
        req_addr[1]  = 5'd2;
        req_wdata[1] = 32'h12345678;
        req_be[1]    = 4'hF;
        step();
        req_valid[1] = 1'b0;
        rst_n[1]     = 1'b0;
        step();
        rst_n[1] = 1'b1;
        bad = (rsp_valid[1] !== 1'b0) ? 1 : 0;
        wait_ready(1, edges);
        n_cmp++;
        if (bad != 0 || edges != 1 || rsp_valid[1] !== 1'b0) begin
            n_bad++;
            $display("FAIL midwait_b: rv_seen=%0d edges=%0d required 0 1", bad, edges);
        end
        do_txn(1, 1'b0, 5'd2, 32'h0, 4'h0, 0, r, lat);
        n_cmp++;
        if (r !== 32'h0BADF00D) begin
            n_bad++;
            $display("FAIL midwait_b_read: got %h required 0badf00d", r);
        end
        // Instance 0: reset two edges after accept, then again partway through the clear.
        req_valid[0] = 1'b1;
        req_we[0]    = 1'b1;
        req_addr[0]  = 5'd2;
        req_wdata[0] = 32'h12345678;
        req_be[0]    = 4'hF;
        step();
        req_valid[0] = 1'b0;
        step();
        rst_n[0] = 1'b0;
        step();
        rst_n[0] = 1'b1;
        n_cmp++;
        if (rsp_valid[0] !== 1'b0 || init_done[0] !== 1'b0 || req_ready[0] !== 1'b0) begin
            n_bad++;
            $display("FAIL midwait_a: rv=%b done=%b rdy=%b required 0 0 0", rsp_valid[0],
                     init_done[0], req_ready[0]);
        end
        repeat (10) step();
        rst_n[0] = 1'b0;
        step();
        rst_n[0] = 1'b1;
        wait_ready(0, edges);
        n_cmp++;
        if (edges != 32 || init_done[0] !== 1'b1) begin
            n_bad++;
            $display("FAIL midinit_restart: edges=%0d done=%b required 32 1", edges, init_done[0]);
        end
        for (int a = 0; a < 32; a++) model[0][a] = 32'h0;
        do_txn(0, 1'b0, 5'd2, 32'h0, 4'h0, 0, r, lat);
        n_cmp++;
        if (r !== 32'h0) begin
            n_bad++;
            $display("FAIL midwait_a_read: got %h required 00000000", r);
        end
    endtask

    task automatic test_random();
        logic [31:0] r, wd, exp;
        logic [4:0]  a;
        logic [3:0]  be;
        logic        we;
        int          d, lat;
        for (int n = 0; n < 80; n++) begin
            d  = int'($urandom_range(0, 1));
            a  = 5'($urandom_range(0, 31));
            wd = $urandom;
            be = 4'($urandom_range(0, 15));
            we = 1'($urandom_range(0, 1));
            if (!known[d][a]) begin
                we = 1'b1;
                be = 4'hF;
            end
            if (we) begin
                model[d][a] = merge(model[d][a], wd, be);
                known[d][a] = 1'b1;
            end
            exp = model[d][a];
            do_txn(d, we, a, wd, be, int'($urandom_range(0, 3)), r, lat);
            n_cmp++;
            if (r !== exp || lat != lat_exp(d)) begin
                n_bad++;
                $display("FAIL random[%0d] d=%0d we=%b a=%0d be=%b: data=%h lat=%0d required %h %0d",
                         n, d, we, a, be, r, lat, exp, lat_exp(d));
            end
        end
    endtask

    initial begin
        n_cmp     = 0;
        n_bad     = 0;
        rst_n     = 2'b00;
        req_valid = '0;
        req_we    = '0;
        req_addr  = '0;
        req_wdata = '0;
        req_be    = '0;
        rsp_ready = '0;
        test_reset();
        test_clear();
        test_full_word();
        test_byte_mask();
        test_latency_backpressure();
        test_reset_mid_op();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
